cacheline_arbiter: RTL and testbench

- Shares the single 256-bit physical memory port between the I-cache line port (a-side) and the D-cache line port (b-side).
- Sits between the two caches and the cacheline adaptor.
- Serialises line reads and writebacks one at a time, with round-robin or fixed-priority grant.
- Raises sticky flags for protocol errors and stalled transactions, so the shadow-memory-checked bench can localise memory hangs.

---
 rtl/cacheline_arbiter_if.sv | 61 ++++++
 rtl/cacheline_arbiter.sv | 136 +++++++++++++
 tb/tb_cacheline_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : cacheline_arbiter_if
// Purpose  : Bundles the I-cache line port, the D-cache line port, the
//            physical memory port and the sticky status flags of the
//            cacheline arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface cacheline_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
);
    // I-cache (a-side) line port
    logic                  a_read;
    logic [ADDR_WIDTH-1:0] a_address;
    logic [LINE_WIDTH-1:0] a_rdata;
    logic                  a_resp;

    // D-cache (b-side) line port
    logic                  b_read;
    logic                  b_write;
    logic [ADDR_WIDTH-1:0] b_address;
    logic [LINE_WIDTH-1:0] b_wdata;
    logic [LINE_WIDTH-1:0] b_rdata;
    logic                  b_resp;

    // Physical memory port
    logic                  pmem_read;
    logic                  pmem_write;
    logic [ADDR_WIDTH-1:0] pmem_address;
    logic [LINE_WIDTH-1:0] pmem_wdata;
    logic [LINE_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    // Sticky status flags
    logic                  err_proto;
    logic                  err_timeout;

    // Arbiter view
    modport slave (
        input  a_read, a_address,
        output a_rdata, a_resp,
        input  b_read, b_write, b_address, b_wdata,
        output b_rdata, b_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp,
        output err_proto, err_timeout
    );

    // Environment view: the two caches plus the memory adaptor
    modport master (
        output a_read, a_address,
        input  a_rdata, a_resp,
        output b_read, b_write, b_address, b_wdata,
        input  b_rdata, b_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp,
        input  err_proto, err_timeout
    );
endinterface
`default_nettype wire

// File: rtl/cacheline_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cacheline_arbiter
// Purpose  : Shares one cacheline-wide memory port between the I-cache
//            (a-side) and the D-cache (b-side). One transaction at a time,
//            round-robin or b-wins tie breaking, with sticky flags for
//            read+write collisions and over-long transactions.
// Revision : 1.0 - initial release
// ============================================================================
module cacheline_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int LINE_WIDTH     = 256,
    parameter int PRIORITY_MODE  = 0,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    cacheline_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_A  = 2'd1,
        BUSY_B  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [15:0] c_timeout  = 16'(TIMEOUT_CYCLES);
    localparam logic [15:0] c_cnt_max  = 16'hFFFF;

    state_t                r_state;
    logic                  r_pmem_read;
    logic                  r_pmem_write;
    logic [ADDR_WIDTH-1:0] r_pmem_address;
    logic [LINE_WIDTH-1:0] r_pmem_wdata;
    logic                  r_err_proto;
    logic                  r_err_timeout;
    logic [15:0]           r_busy_cnt;
    logic                  r_last_grant_b;   // 1: most recent grant went to b

    logic                  w_req_a;
    logic                  w_req_b;
    logic                  w_pick_b;
    logic [15:0]           w_cnt_next;
    logic                  w_unused_low_addr;

    // Request decode, tie breaking and saturating busy-count increment
    always_comb begin
        w_req_a    = bus.a_read;
        w_req_b    = bus.b_read | bus.b_write;
        // b wins when alone, when b-priority is configured, or when a had
        // the previous grant under round-robin.
        w_pick_b   = w_req_b && (!w_req_a || (PRIORITY_MODE != 0) || !r_last_grant_b);
        w_cnt_next = (r_busy_cnt == c_cnt_max) ? r_busy_cnt : r_busy_cnt + 16'd1;
    end

    // Line offset bits never reach memory; addresses are forced to line alignment
    assign w_unused_low_addr = ^{bus.a_address[4:0], bus.b_address[4:0]};

    // Read data flows straight through to both caches; only resp qualifies it
    assign bus.a_rdata      = bus.pmem_rdata;
    assign bus.b_rdata      = bus.pmem_rdata;
    assign bus.a_resp       = (r_state == BUSY_A) && bus.pmem_resp;
    assign bus.b_resp       = (r_state == BUSY_B) && bus.pmem_resp;

    assign bus.pmem_read    = r_pmem_read;
    assign bus.pmem_write   = r_pmem_write;
    assign bus.pmem_address = r_pmem_address;
    assign bus.pmem_wdata   = r_pmem_wdata;
    assign bus.err_proto    = r_err_proto;
    assign bus.err_timeout  = r_err_timeout;

    // Grant/complete state machine with registered memory strobes and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= '0;
            r_pmem_wdata   <= '0;
            r_err_proto    <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_busy_cnt     <= '0;
            r_last_grant_b <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req_a || w_req_b) begin
                        r_busy_cnt <= '0;
                        if (w_pick_b) begin
                            r_state        <= BUSY_B;
                            r_last_grant_b <= 1'b1;
                            r_pmem_address <= {bus.b_address[ADDR_WIDTH-1:5], 5'b0};
                            // A read+write collision is carried out as a write
                            r_pmem_write   <= bus.b_write;
                            r_pmem_read    <= ~bus.b_write;
                            if (bus.b_write) begin
                                r_pmem_wdata <= bus.b_wdata;
                            end
                            if (bus.b_read && bus.b_write) begin
                                r_err_proto <= 1'b1;
                            end
                        end else begin
                            r_state        <= BUSY_A;
                            r_last_grant_b <= 1'b0;
                            r_pmem_address <= {bus.a_address[ADDR_WIDTH-1:5], 5'b0};
                            r_pmem_read    <= 1'b1;
                            r_pmem_write   <= 1'b0;
                        end
                    end
                end
                BUSY_A, BUSY_B: begin
                    r_busy_cnt <= w_cnt_next;
                    // The flag only reports; the transaction keeps waiting
                    if ((TIMEOUT_CYCLES != 0) && (w_cnt_next == c_timeout)) begin
                        r_err_timeout <= 1'b1;
                    end
                    if (bus.pmem_resp) begin
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                        r_state      <= RELEASE;
                    end
                end
                RELEASE: begin
                    // One dead cycle so the finished requester can drop its request
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cacheline_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cacheline_arbiter
// Purpose  : Directed self-checking bench for cacheline_arbiter. dut0 runs
//            round-robin with an 8-cycle timeout, dut1 runs b-priority with
//            the timeout disabled; both see identical stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cacheline_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    localparam logic [255:0] c_line1 = {8{32'hA5A5_0001}};
    localparam logic [255:0] c_line2 = {8{32'h5A5A_0002}};
    localparam logic [255:0] c_line3 = {8{32'hC3C3_0003}};
    localparam logic [255:0] c_line4 = {8{32'h1111_0004}};
    localparam logic [255:0] c_wline = {8{32'hDEAD_BEEF}};
    localparam logic [255:0] c_wline2 = {8{32'hCAFE_F00D}};

    cacheline_arbiter_if #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) if0 ();
    cacheline_arbiter_if #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) if1 ();

    assign if1.a_read     = if0.a_read;
    assign if1.a_address  = if0.a_address;
    assign if1.b_read     = if0.b_read;
    assign if1.b_write    = if0.b_write;
    assign if1.b_address  = if0.b_address;
    assign if1.b_wdata    = if0.b_wdata;
    assign if1.pmem_rdata = if0.pmem_rdata;
    assign if1.pmem_resp  = if0.pmem_resp;

    cacheline_arbiter #(
        .ADDR_WIDTH(32), .LINE_WIDTH(256), .PRIORITY_MODE(0), .TIMEOUT_CYCLES(8)
    ) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    cacheline_arbiter #(
        .ADDR_WIDTH(32), .LINE_WIDTH(256), .PRIORITY_MODE(1), .TIMEOUT_CYCLES(0)
    ) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and step just past the last one
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        if0.a_read    = 1'b0;
        if0.a_address = '0;
        if0.b_read    = 1'b0;
        if0.b_write   = 1'b0;
        if0.b_address = '0;
        if0.b_wdata   = '0;
        if0.pmem_rdata = '0;
        if0.pmem_resp = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({if0.pmem_read, if0.pmem_write} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b want 00", {if0.pmem_read, if0.pmem_write}); end
        checks++; if (if0.pmem_address !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", if0.pmem_address); end
        checks++; if (if0.pmem_wdata !== 256'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", if0.pmem_wdata); end
        checks++; if ({if0.err_proto, if0.err_timeout, if1.err_proto, if1.err_timeout} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", {if0.err_proto, if0.err_timeout, if1.err_proto, if1.err_timeout}); end
        checks++; if ({if0.a_resp, if0.b_resp, if1.pmem_read, if1.pmem_write} !== 4'b0000) begin errors++; $display("FAIL reset_misc got %b want 0000", {if0.a_resp, if0.b_resp, if1.pmem_read, if1.pmem_write}); end
    endtask

    task automatic test_tie();
        cyc(1);
        if0.a_read    = 1'b1;
        if0.a_address = 32'h1000_0044;
        if0.b_read    = 1'b1;
        if0.b_address = 32'h2000_0088;
        @(negedge clk);
        checks++; if (if0.pmem_read !== 1'b0) begin errors++; $display("FAIL tie_latency got %b want 0", if0.pmem_read); end
        // First grant: dut0 picks a (last_grant resets to b), dut1 picks b
        cyc(1);
        @(negedge clk);
        checks++; if ({if0.pmem_read, if0.pmem_address} !== {1'b1, 32'h1000_0040}) begin errors++; $display("FAIL tie_rr_first got %b/%h want 1/10000040", if0.pmem_read, if0.pmem_address); end
        checks++; if ({if1.pmem_read, if1.pmem_address} !== {1'b1, 32'h2000_0080}) begin errors++; $display("FAIL tie_pri_first got %b/%h want 1/20000080", if1.pmem_read, if1.pmem_address); end
        checks++; if (if0.b_resp !== 1'b0) begin errors++; $display("FAIL tie_no_bresp_busy_a got %b want 0", if0.b_resp); end
        cyc(1);
        if0.pmem_rdata = c_line1;
        if0.pmem_resp  = 1'b1;
        @(negedge clk);
        checks++; if ({if0.a_resp, if0.b_resp} !== 2'b10) begin errors++; $display("FAIL tie_rr_resp1 got %b want 10", {if0.a_resp, if0.b_resp}); end
        checks++; if (if0.a_rdata !== c_line1) begin errors++; $display("FAIL tie_rr_rdata1 got %h want %h", if0.a_rdata, c_line1); end
        checks++; if ({if1.a_resp, if1.b_resp} !== 2'b01) begin errors++; $display("FAIL tie_pri_resp1 got %b want 01", {if1.a_resp, if1.b_resp}); end
        cyc(1);
        if0.pmem_resp = 1'b0;
        @(negedge clk);
        checks++; if ({if0.pmem_read, if0.a_resp} !== 2'b00) begin errors++; $display("FAIL tie_release got %b want 00", {if0.pmem_read, if0.a_resp}); end
        cyc(1);
        @(negedge clk);
        checks++; if ({if0.pmem_read, if1.pmem_read} !== 2'b00) begin errors++; $display("FAIL tie_idle got %b want 00", {if0.pmem_read, if1.pmem_read}); end
        // Three cycles after the first resp the other side is granted
        cyc(1);
        @(negedge clk);
        checks++; if ({if0.pmem_read, if0.pmem_address} !== {1'b1, 32'h2000_0080}) begin errors++; $display("FAIL tie_rr_second got %b/%h want 1/20000080", if0.pmem_read, if0.pmem_address); end
        checks++; if ({if1.pmem_read, if1.pmem_address} !== {1'b1, 32'h2000_0080}) begin errors++; $display("FAIL tie_pri_second got %b/%h want 1/20000080", if1.pmem_read, if1.pmem_address); end
        cyc(1);
        if0.pmem_rdata = c_line2;
        if0.pmem_resp  = 1'b1;
        @(negedge clk);
        checks++; if ({if0.a_resp, if0.b_resp} !== 2'b01) begin errors++; $display("FAIL tie_rr_resp2 got %b want 01", {if0.a_resp, if0.b_resp}); end
        checks++; if (if0.b_rdata !== c_line2) begin errors++; $display("FAIL tie_rr_rdata2 got %h want %h", if0.b_rdata, c_line2); end
        cyc(1);
        if0.pmem_resp = 1'b0;
        cyc(2);
        @(negedge clk);
        checks++; if ({if0.pmem_read, if0.pmem_address} !== {1'b1, 32'h1000_0040}) begin errors++; $display("FAIL tie_rr_third got %b/%h want 1/10000040", if0.pmem_read, if0.pmem_address); end
        checks++; if ({if1.pmem_read, if1.pmem_address} !== {1'b1, 32'h2000_0080}) begin errors++; $display("FAIL tie_pri_third got %b/%h want 1/20000080", if1.pmem_read, if1.pmem_address); end
        cyc(1);
        if0.pmem_rdata = c_line3;
        if0.pmem_resp  = 1'b1;
        @(negedge clk);
        checks++; if ({if0.a_resp, if0.b_resp} !== 2'b10) begin errors++; $display("FAIL tie_rr_resp3 got %b want 10", {if0.a_resp, if0.b_resp}); end
        cyc(1);
        if0.pmem_resp = 1'b0;
        if0.a_read    = 1'b0;
        if0.b_read    = 1'b0;
        cyc(3);
    endtask

    task automatic test_lone_read();
        if0.a_read    = 1'b1;
        if0.a_address = 32'h0000_0064;
        cyc(1);
        @(negedge clk);
        checks++; if ({if0.pmem_read, if0.pmem_write, if0.pmem_address} !== {2'b10, 32'h0000_0060}) begin errors++; $display("FAIL lone_grant got %b%b/%h want 10/00000060", if0.pmem_read, if0.pmem_write, if0.pmem_address); end
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            @(negedge clk);
            checks++; if ({if0.pmem_read, if0.a_resp, if0.b_resp} !== 3'b100) begin errors++; $display("FAIL lone_wait%0d got %b want 100", i, {if0.pmem_read, if0.a_resp, if0.b_resp}); end
        end
        cyc(1);
        if0.pmem_rdata = c_line4;
        if0.pmem_resp  = 1'b1;
        @(negedge clk);
        checks++; if ({if0.a_resp, if0.b_resp} !== 2'b10) begin errors++; $display("FAIL lone_resp got %b want 10", {if0.a_resp, if0.b_resp}); end
        checks++; if (if0.a_rdata !== c_line4) begin errors++; $display("FAIL lone_rdata got %h want %h", if0.a_rdata, c_line4); end
        cyc(1);
        if0.pmem_resp = 1'b0;
        if0.a_read    = 1'b0;
        @(negedge clk);
        checks++; if ({if0.pmem_read, if0.a_resp} !== 2'b00) begin errors++; $display("FAIL lone_release got %b want 00", {if0.pmem_read, if0.a_resp}); end
        cyc(1);
        @(negedge clk);
        checks++; if (if0.pmem_read !== 1'b0) begin errors++; $display("FAIL lone_idle got %b want 0", if0.pmem_read); end
        cyc(1);
    endtask

    task automatic test_writeback();
        if0.b_write   = 1'b1;
        if0.b_address = 32'h8000_00A4;
        if0.b_wdata   = c_wline;
        cyc(1);
        @(negedge clk);
        checks++; if ({if0.pmem_read, if0.pmem_write, if0.pmem_address} !== {2'b01, 32'h8000_00A0}) begin errors++; $display("FAIL wb_grant got %b%b/%h want 01/800000a0", if0.pmem_read, if0.pmem_write, if0.pmem_address); end
        checks++; if (if0.pmem_wdata !== c_wline) begin errors++; $display("FAIL wb_wdata got %h want %h", if0.pmem_wdata, c_wline); end
        cyc(1);
        if0.b_address = 32'h1234_5678;
        if0.b_wdata   = ~c_wline;
        @(negedge clk);
        checks++; if ({if0.pmem_address, if0.b_resp} !== {32'h8000_00A0, 1'b0}) begin errors++; $display("FAIL wb_addr_latched got %h/%b want 800000a0/0", if0.pmem_address, if0.b_resp); end
        checks++; if (if0.pmem_wdata !== c_wline) begin errors++; $display("FAIL wb_wdata_latched got %h want %h", if0.pmem_wdata, c_wline); end
        cyc(1);
        if0.pmem_resp = 1'b1;
        @(negedge clk);
        checks++; if ({if0.a_resp, if0.b_resp} !== 2'b01) begin errors++; $display("FAIL wb_resp got %b want 01", {if0.a_resp, if0.b_resp}); end
        cyc(1);
        if0.pmem_resp = 1'b0;
        if0.b_write   = 1'b0;
        @(negedge clk);
        checks++; if ({if0.pmem_write, if0.b_resp} !== 2'b00) begin errors++; $display("FAIL wb_release got %b want 00", {if0.pmem_write, if0.b_resp}); end
        cyc(2);
    endtask

    task automatic test_proto_timeout();
        @(negedge clk);
        checks++; if ({if0.err_proto, if0.err_timeout} !== 2'b00) begin errors++; $display("FAIL pt_flags_before got %b want 00", {if0.err_proto, if0.err_timeout}); end
        cyc(1);
        if0.b_read    = 1'b1;
        if0.b_write   = 1'b1;
        if0.b_address = 32'h4000_0010;
        if0.b_wdata   = c_wline2;
        // Grant edge; first BUSY cycle follows
        cyc(1);
        @(negedge clk);
        checks++; if ({if0.pmem_read, if0.pmem_write, if0.err_proto} !== 3'b011) begin errors++; $display("FAIL pt_write_proto got %b want 011", {if0.pmem_read, if0.pmem_write, if0.err_proto}); end
        checks++; if (if0.pmem_wdata !== c_wline2) begin errors++; $display("FAIL pt_wdata got %h want %h", if0.pmem_wdata, c_wline2); end
        // Seventh BUSY cycle: fewer than 8 cycles elapsed
        cyc(6);
        @(negedge clk);
        checks++; if (if0.err_timeout !== 1'b0) begin errors++; $display("FAIL pt_timeout_early got %b want 0", if0.err_timeout); end
        // Tenth BUSY cycle: more than 8 cycles elapsed
        cyc(3);
        @(negedge clk);
        checks++; if ({if0.err_timeout, if0.pmem_write} !== 2'b11) begin errors++; $display("FAIL pt_timeout_set got %b want 11", {if0.err_timeout, if0.pmem_write}); end
        checks++; if (if1.err_timeout !== 1'b0) begin errors++; $display("FAIL pt_timeout_disabled got %b want 0", if1.err_timeout); end
        cyc(11);
        if0.pmem_resp = 1'b1;
        @(negedge clk);
        checks++; if (if0.b_resp !== 1'b1) begin errors++; $display("FAIL pt_completes got %b want 1", if0.b_resp); end
        cyc(1);
        if0.pmem_resp = 1'b0;
        if0.b_read    = 1'b0;
        if0.b_write   = 1'b0;
        @(negedge clk);
        checks++; if (if0.pmem_write !== 1'b0) begin errors++; $display("FAIL pt_release got %b want 0", if0.pmem_write); end
        cyc(3);
        @(negedge clk);
        checks++; if ({if0.err_proto, if0.err_timeout, if1.err_proto} !== 3'b111) begin errors++; $display("FAIL pt_sticky got %b want 111", {if0.err_proto, if0.err_timeout, if1.err_proto}); end
        cyc(1);
    endtask

    task automatic test_reset_mid();
        if0.a_read    = 1'b1;
        if0.a_address = 32'h0000_0100;
        cyc(1);
        @(negedge clk);
        checks++; if (if0.pmem_read !== 1'b1) begin errors++; $display("FAIL rm_busy got %b want 1", if0.pmem_read); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (if0.pmem_read !== 1'b0) begin errors++; $display("FAIL rm_async_drop got %b want 0", if0.pmem_read); end
        checks++; if ({if0.err_proto, if0.err_timeout} !== 2'b00) begin errors++; $display("FAIL rm_flags_cleared got %b want 00", {if0.err_proto, if0.err_timeout}); end
        if0.a_read = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        if0.pmem_rdata = c_line1;
        if0.pmem_resp  = 1'b1;
        @(negedge clk);
        checks++; if ({if0.a_resp, if0.b_resp, if0.pmem_read} !== 3'b000) begin errors++; $display("FAIL rm_stray_resp got %b want 000", {if0.a_resp, if0.b_resp, if0.pmem_read}); end
        checks++; if ({if1.a_resp, if1.b_resp} !== 2'b00) begin errors++; $display("FAIL rm_stray_resp1 got %b want 00", {if1.a_resp, if1.b_resp}); end
        cyc(1);
        @(negedge clk);
        checks++; if ({if0.a_resp, if0.b_resp, if0.pmem_read, if0.pmem_write} !== 4'b0000) begin errors++; $display("FAIL rm_idle got %b want 0000", {if0.a_resp, if0.b_resp, if0.pmem_read, if0.pmem_write}); end
        cyc(1);
        if0.pmem_resp = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_tie();
        test_lone_read();
        test_writeback();
        test_proto_timeout();
        test_reset_mid();
        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
